// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall detection.
// Bubbles zero the control fields; forwarded operands are combinational from the EX registers.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_alucontrol,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_writereg,
  input  logic [31:0] mem_aluresult,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_writereg,
  input  logic [31:0] wb_result,
  output logic [31:0] scrA,
  output logic [31:0] scrB,
  output logic [3:0]  alucontrol,
  output logic        ex_valid,
  output logic [4:0]  ex_writereg,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [31:0] ex_writedata,
  output logic        stall
);

  logic        valid_q,      valid_d;
  logic [4:0]  rs_q,         rs_d;
  logic [4:0]  rt_q,         rt_d;
  logic [4:0]  writereg_q,   writereg_d;
  logic [31:0] rd1_q,        rd1_d;
  logic [31:0] rd2_q,        rd2_d;
  logic [31:0] imm_q,        imm_d;
  logic [3:0]  alucontrol_q, alucontrol_d;
  logic        alusrc_q,     alusrc_d;
  logic        regwrite_q,   regwrite_d;
  logic        memread_q,    memread_d;
  logic        memwrite_q,   memwrite_d;

  logic        bubble;
  logic        ld_hit;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  // A load in EX whose destination feeds the decoding instruction must wait one cycle.
  always_comb begin
    ld_hit = (writereg_q == id_rs) || (writereg_q == id_rt);
    stall  = id_valid && valid_q && memread_q && (writereg_q != 5'd0) && ld_hit;
  end

  assign bubble = flush || stall || !id_valid;

  always_comb begin
    valid_d      = 1'b0;
    rs_d         = 5'd0;
    rt_d         = 5'd0;
    writereg_d   = 5'd0;
    rd1_d        = 32'd0;
    rd2_d        = 32'd0;
    imm_d        = 32'd0;
    alucontrol_d = 4'd0;
    alusrc_d     = 1'b0;
    regwrite_d   = 1'b0;
    memread_d    = 1'b0;
    memwrite_d   = 1'b0;
    if (!bubble) begin
      valid_d      = 1'b1;
      rs_d         = id_rs;
      rt_d         = id_rt;
      writereg_d   = id_regdst ? id_rd : id_rt;
      rd1_d        = id_rd1;
      rd2_d        = id_rd2;
      imm_d        = id_imm;
      alucontrol_d = id_alucontrol;
      alusrc_d     = id_alusrc;
      regwrite_d   = id_regwrite;
      memread_d    = id_memread;
      memwrite_d   = id_memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      writereg_q   <= 5'd0;
      rd1_q        <= 32'd0;
      rd2_q        <= 32'd0;
      imm_q        <= 32'd0;
      alucontrol_q <= 4'd0;
      alusrc_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      writereg_q   <= writereg_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      alucontrol_q <= alucontrol_d;
      alusrc_q     <= alusrc_d;
      regwrite_q   <= regwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
    end
  end

  // MEM result is younger than WB, so it wins; $zero is never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == rs_q)) begin
      fwd_a = mem_aluresult;
    end else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == rs_q)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = rd2_q;
    if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == rt_q)) begin
      fwd_b = mem_aluresult;
    end else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == rt_q)) begin
      fwd_b = wb_result;
    end
  end

  assign scrA         = fwd_a;
  assign scrB         = alusrc_q ? imm_q : fwd_b;
  assign ex_writedata = fwd_b;
  assign alucontrol   = alucontrol_q;
  assign ex_valid     = valid_q;
  assign ex_writereg  = writereg_q;
  assign ex_regwrite  = regwrite_q;
  assign ex_memread   = memread_q;
  assign ex_memwrite  = memwrite_q;

endmodule
